// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide unit owning the HI/LO registers.
// One shared adder/subtractor performs one shift-add or restoring-divide step per cycle.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_hilo,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH-1:0] r_acc;   // multiply: acc, divide: remainder
  logic [WIDTH-1:0] r_mq;    // multiply: mq,  divide: quotient
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_done;

  logic             w_accept, w_finish, w_last;
  logic [WIDTH:0]   w_shift_r;
  logic [WIDTH+1:0] w_x, w_y, w_sum;
  logic             w_neg;
  logic [WIDTH-1:0] w_acc_nxt, w_mq_nxt;

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value held and no latch is inferred.
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !flush) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shared datapath: add for multiply, subtract (two's complement) for divide.
  always_comb begin
    w_shift_r = {r_acc, r_mq[WIDTH-1]};
    if (r_op) begin
      w_x = {1'b0, w_shift_r};
      w_y = {2'b00, r_b};
    end else begin
      w_x = {2'b00, r_acc};
      w_y = r_mq[0] ? {2'b00, r_a} : '0;
    end
    w_sum = w_x + (w_y ^ {(WIDTH+2){r_op}}) + (WIDTH+2)'(r_op);
    w_neg = w_sum[WIDTH+1];
    if (r_op) begin
      w_acc_nxt = w_neg ? w_shift_r[WIDTH-1:0] : w_sum[WIDTH-1:0];
      w_mq_nxt  = {r_mq[WIDTH-2:0], ~w_neg};
    end else begin
      w_acc_nxt = w_sum[WIDTH:1];
      w_mq_nxt  = {w_sum[0], r_mq[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_op   <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_mq   <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_op  <= op;
        r_a   <= a;
        r_b   <= b;
        r_cnt <= '0;
        r_acc <= '0;
        r_mq  <= op ? a : b;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + CW'(1);
        r_acc <= w_acc_nxt;
        r_mq  <= w_mq_nxt;
      end
      if (w_finish) begin
        r_hi <= w_acc_nxt;
        r_lo <= w_mq_nxt;
      end
    end
  end

  assign busy  = (r_state == S_RUN);
  assign stall = busy & (start | rd_hilo);
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule
